// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared states and framing constants for the instruction memory loader.
package instr_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WR, CHK, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES = 2;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs accepted bytes little-endian into a 32-bit word, flags the 4th byte.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);
  logic [23:0] sh;
  logic [1:0] cnt;
  // the 4th byte completes the word directly from din, so the word is ready in the accept cycle
  assign full = shift & (cnt == 2'(BYTES_PER_WORD - 1));
  assign word = {din, sh};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh <= '0;
      cnt <= '0;
    end else if (shift) begin
      sh <= {din, sh[23:8]};
      cnt <= cnt + 2'd1;
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a length-prefixed byte stream and writes it as 32-bit words to
// instruction memory. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, state_n;
  logic [7:0] len_lo, csum;
  logic len_hi;
  logic [ADDR_W:0] len;
  logic [15:0] n;
  logic go, xfer, shift, asm_full;
  logic [31:0] asm_word;
  assign go = start & (state == IDLE || state == DONE || state == ERR);
  assign xfer = rx_valid & rx_ready;
  assign shift = xfer & (state == DATA);
  assign n = {rx_data, len_lo};
  assign rx_ready = state inside {LEN, DATA, CHK};
  assign busy = state inside {LEN, DATA, WR, CHK};
  assign mem_we = state == WR;
  assign done = state == DONE;
  assign err = state == ERR;
  word_assembler u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clr(go),
    .shift(shift),
    .din(rx_data),
    .word(asm_word),
    .full(asm_full)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (go) state_n = LEN;
    else
      case (state)
        LEN: if (xfer && len_hi) state_n = n > 16'(DEPTH) ? ERR : n == 16'd0 ? FIN : DATA;
        DATA: if (asm_full) state_n = WR;
        WR: state_n = words_loaded == len ? FIN : DATA;
        CHK: if (xfer) state_n = rx_data == csum ? DONE : ERR;
        default: state_n = state;
      endcase
  end
  // words_loaded doubles as the next write address; it steps on the edge that raises mem_we
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_lo <= '0;
      len_hi <= 1'b0;
      len <= '0;
      csum <= '0;
      words_loaded <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else if (go) begin
      len_hi <= 1'b0;
      csum <= '0;
      words_loaded <= '0;
      mem_addr <= '0;
    end else begin
      if (state == LEN && xfer) begin
        len_lo <= rx_data;
        len_hi <= 1'b1;
        len <= n[ADDR_W:0];
      end
      if (shift) csum <= csum ^ rx_data;
      if (asm_full) begin
        mem_wdata <= DATA_W'(asm_word);
        mem_addr <= words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + 1'b1;
      end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed tests of framing, writes, length limits, reset abort and checksum.
module tb_instr_mem_loader;
  logic clk = 0, rst_n = 0, start = 0, rx_valid = 0;
  logic [7:0] rx_data = '0;
  logic rx_ready, mem_we, busy, done, err;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;
  int checks = 0, errors = 0, nw = 0;
  logic [9:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  logic [7:0] tcs;
  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (mem_we && nw < 32) begin
      wr_addr[nw] = mem_addr;
      wr_data[nw] = mem_wdata;
      nw++;
    end

  task automatic pulse_start;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    tcs = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(w[8*i +: 8]);
      tcs ^= w[8*i +: 8];
    end
  endtask

  task automatic send_chk;
`ifdef LOADER_CHECKSUM_EN
    send_byte(tcs);
`endif
  endtask

  task automatic wait_end;
    int t = 0;
    while (!(done || err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_end timeout: done=%b err=%b", done, err);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, err, rx_ready, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {busy, done, err, rx_ready, mem_we});
    end
    checks++;
    if ({words_loaded, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_regs: wl=%0d addr=%0d wdata=%h required 0", words_loaded, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_basic;
    nw = 0;
    pulse_start;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b required 1", busy);
    end
    send_len(16'd2);
    send_word(32'h00000013, 0);
    send_word(32'h00100093, 0);
    send_chk;
    wait_end;
    checks++;
    if ({done, err, busy, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_status: done/err/busy/ready=%b required 1000", {done, err, busy, rx_ready});
    end
    checks++;
    if (words_loaded !== 11'd2 || nw != 2) begin
      errors++;
      $display("FAIL basic_count: wl=%0d writes=%0d required 2", words_loaded, nw);
    end
    checks++;
    if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00000013) begin
      errors++;
      $display("FAIL basic_w0: addr=%0d data=%h required 0 00000013", wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00100093) begin
      errors++;
      $display("FAIL basic_w1: addr=%0d data=%h required 1 00100093", wr_addr[1], wr_data[1]);
    end
    checks++;
    if (mem_addr !== 10'd1 || mem_wdata !== 32'h00100093) begin
      errors++;
      $display("FAIL basic_hold: addr=%0d data=%h required 1 00100093", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_overlength;
    nw = 0;
    pulse_start;
    send_len(16'h0401);
    checks++;
    if ({err, done, rx_ready, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL overlen_status: err/done/ready/busy=%b required 1000", {err, done, rx_ready, busy});
    end
    rx_data = 8'h55;
    rx_valid = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || nw != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL overlen_drop: ready=%b writes=%0d err=%b required 0 0 1", rx_ready, nw, err);
    end
    rx_valid = 0;
  endtask

  task automatic test_zero_len;
    nw = 0;
    pulse_start;
    send_len(16'd0);
    send_chk;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 11'd0 || nw != 0) begin
      errors++;
      $display("FAIL zero_len: done=%b err=%b wl=%0d writes=%0d required 1 0 0 0", done, err, words_loaded, nw);
    end
  endtask

  task automatic test_start_busy;
    nw = 0;
    pulse_start;
    send_len(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    tcs = 8'h33;
    pulse_start;
    tcs = 8'h33;
    checks++;
    if (busy !== 1'b1 || words_loaded !== 11'd0) begin
      errors++;
      $display("FAIL start_busy_state: busy=%b wl=%0d required 1 0", busy, words_loaded);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    tcs = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
    send_chk;
    wait_end;
    checks++;
    if (done !== 1'b1 || nw != 1 || wr_data[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL start_busy_word: done=%b writes=%0d data=%h required 1 1 44332211", done, nw, wr_data[0]);
    end
  endtask

  task automatic test_gaps;
    logic [31:0] img [0:7];
    for (int i = 0; i < 8; i++) img[i] = {8'(i + 1), 8'(i * 3), 8'hA5 ^ 8'(i), 8'(i)};
    nw = 0;
    pulse_start;
    send_len(16'd8);
    for (int i = 0; i < 8; i++) send_word(img[i], 5);
    send_chk;
    wait_end;
    checks++;
    if (done !== 1'b1 || nw != 8 || words_loaded !== 11'd8) begin
      errors++;
      $display("FAIL gaps_count: done=%b writes=%0d wl=%0d required 1 8 8", done, nw, words_loaded);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr[i] !== 10'(i) || wr_data[i] !== img[i]) begin
        errors++;
        $display("FAIL gaps_w%0d: addr=%0d data=%h required %0d %h", i, wr_addr[i], wr_data[i], i, img[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    nw = 0;
    pulse_start;
    send_len(16'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, err, rx_ready, mem_we} !== 5'b0 || {words_loaded, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b wl=%0d addr=%0d data=%h required all 0",
               {busy, done, err, rx_ready, mem_we}, words_loaded, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (nw != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: writes=%0d busy=%b required 0 0", nw, busy);
    end
    pulse_start;
    send_len(16'd1);
    send_word(32'h12345678, 1);
    send_chk;
    wait_end;
    checks++;
    if (done !== 1'b1 || nw != 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_mid_reload: done=%b writes=%0d addr=%0d data=%h required 1 1 0 12345678",
               done, nw, wr_addr[0], wr_data[0]);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    nw = 0;
    pulse_start;
    send_len(16'd1);
    send_word(32'hDDCCBBAA, 0);
    send_byte(8'h00);
    wait_end;
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL chk_good: done=%b err=%b required 1 0", done, err);
    end
    nw = 0;
    pulse_start;
    send_len(16'd1);
    send_word(32'hDDCCBBAA, 0);
    send_byte(8'h01);
    wait_end;
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || nw != 1 || wr_data[0] !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL chk_bad: err=%b done=%b writes=%0d data=%h required 1 0 1 ddccbbaa", err, done, nw, wr_data[0]);
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_basic;
    test_overlength;
    test_zero_len;
    test_start_busy;
    test_gaps;
    test_reset_mid;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
